// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
//
// Groups every non-clock/reset signal of the frame-buffer SRAM arbiter.
//
//   Client side : rd_req/rd_addr -> rd_data/rd_valid (display scan-out)
//                 wr_req/wr_addr/wr_data -> wr_ready (image loader)
//                 o_idle (write path fully drained)
//   SRAM side   : sram_addr, sram_dq_o, sram_dq_oe, sram_dq_i and the
//                 active-low strobes ce/oe/we/lb/ub. The DQ tristate lives
//                 at the top level, so DQ is split into in/out/enable.
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding system (clients plus the SRAM pad logic)
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              o_idle;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_lb_n;
  logic              sram_ub_n;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_i,
    output rd_data, rd_valid, wr_ready, o_idle,
    output sram_addr, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_i,
    input  rd_data, rd_valid, wr_ready, o_idle,
    input  sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 1Mx16 frame-buffer SRAM between a hard real-time
// display read port and a buffered pixel write port.
//
//   - Reads always win and have a fixed 2-cycle latency
//     (request in N, SRAM read strobes in N+1, rd_valid/rd_data in N+2).
//   - Writes are queued in a FIFO_DEPTH-entry FIFO and drained into slots
//     where no read is requested. Writes may starve under continuous reads;
//     the loader simply stalls on wr_ready until blanking frees the bus.
//   - Every SRAM-facing output is registered; the slot chosen in cycle N is
//     what the SRAM sees during cycle N+1.
//
// Ports:
//   avm_clk  - single clock, rising edge
//   avm_rst  - synchronous, active-high reset (flushes FIFO, drops reads)
//   bus      - sram_arbiter_if.slave: client read/write ports, o_idle and the
//              split SRAM bus (addr, dq_o/dq_oe/dq_i, active-low strobes)
//
// Parameters:
//   FIFO_DEPTH - write FIFO entries, power of two, >= 2
//   ADDR_W     - SRAM word address width
//   DATA_W     - SRAM data width
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16
) (
  input logic           avm_clk,
  input logic           avm_rst,
  sram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Which operation the SRAM bus is carrying during the current cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } slot_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  slot_t            slot;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  wr_entry_t        head;

  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // Readiness depends only on the registered count, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign bus.wr_ready = (count != FULL_CNT) && !avm_rst;
  assign push         = bus.wr_req && bus.wr_ready;

  // A pop steals the slot only when no read is asking for it. Because the
  // count is registered, an entry pushed this cycle is not yet visible here.
  assign pop = !bus.rd_req && !fifo_empty && !avm_rst;

  assign bus.o_idle = fifo_empty && (slot != S_WRITE);

  // NOTE: the FIFO storage has no reset; pointers and count define which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge avm_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Slot scheduler with registered SRAM bus and read capture. The state is
  // the slot currently on the bus; its outputs are the SRAM strobes.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      slot           <= S_IDLE;
      bus.sram_addr  <= '0;
      bus.sram_dq_o  <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_lb_n  <= 1'b1;
      bus.sram_ub_n  <= 1'b1;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
    end else begin
      // Data of a read slot is taken at the end of that slot, which fixes
      // the total read latency at two cycles.
      bus.rd_valid <= (slot == S_READ);
      if (slot == S_READ) begin
        bus.rd_data <= bus.sram_dq_i;
      end

      if (bus.rd_req) begin
        slot           <= S_READ;
        bus.sram_addr  <= bus.rd_addr;
        bus.sram_dq_oe <= 1'b0;
        bus.sram_ce_n  <= 1'b0;
        bus.sram_oe_n  <= 1'b0;
        bus.sram_we_n  <= 1'b1;
        bus.sram_lb_n  <= 1'b0;
        bus.sram_ub_n  <= 1'b0;
      end else if (pop) begin
        slot           <= S_WRITE;
        bus.sram_addr  <= head.addr;
        bus.sram_dq_o  <= head.data;
        bus.sram_dq_oe <= 1'b1;
        bus.sram_ce_n  <= 1'b0;
        bus.sram_oe_n  <= 1'b1;
        bus.sram_we_n  <= 1'b0;
        bus.sram_lb_n  <= 1'b0;
        bus.sram_ub_n  <= 1'b0;
      end else begin
        // Address and write data hold their last values while idle.
        slot           <= S_IDLE;
        bus.sram_dq_oe <= 1'b0;
        bus.sram_ce_n  <= 1'b1;
        bus.sram_oe_n  <= 1'b1;
        bus.sram_we_n  <= 1'b1;
        bus.sram_lb_n  <= 1'b1;
        bus.sram_ub_n  <= 1'b1;
      end
    end
  end

endmodule
